// File: rtl/gf256_to_gf16_stream.sv
// GF(2^8) -> GF((2^4)^2) isomorphism converter with a valid/ready output
// register (M) and a one-entry skid register (S). Both entries hold the
// already-mapped {p,q} pair, so the output path is purely registered.
module gf256_to_gf16_stream (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_p,
    output logic [3:0]  out_q,
    output logic [15:0] out_count
);

    logic       m_v;
    logic [7:0] m_pq;
    logic       s_v;
    logic [7:0] s_pq;
    logic [7:0] map_pq;
    logic       in_fire;
    logic       out_fire;

    // Byte-to-pair basis change, applied before either storage entry.
    always_comb begin
        map_pq    = '0;
        map_pq[0] = in_data[4] ^ in_data[5] ^ in_data[6];
        map_pq[1] = in_data[1] ^ in_data[4] ^ in_data[6] ^ in_data[7];
        map_pq[2] = in_data[2] ^ in_data[3] ^ in_data[5] ^ in_data[7];
        map_pq[3] = in_data[5] ^ in_data[7];
        map_pq[4] = in_data[0] ^ in_data[4] ^ in_data[5] ^ in_data[6];
        map_pq[5] = in_data[1] ^ in_data[2];
        map_pq[6] = in_data[1] ^ in_data[7];
        map_pq[7] = in_data[2] ^ in_data[4];
    end

    // Handshake decode; in_ready depends only on the skid flag and flush.
    always_comb begin
        in_ready  = !s_v && !flush;
        in_fire   = in_valid && in_ready;
        out_fire  = m_v && out_ready;
        out_valid = m_v;
        out_p     = m_pq[7:4];
        out_q     = m_pq[3:0];
    end

    // Main/skid register update: S drains into M before new input is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v  <= 1'b0;
            m_pq <= '0;
            s_v  <= 1'b0;
            s_pq <= '0;
        end else if (flush) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
        end else if (s_v) begin
            if (out_fire) begin
                m_pq <= s_pq;
                s_v  <= 1'b0;
            end
        end else if (!m_v || out_fire) begin
            if (in_fire) begin
                m_v  <= 1'b1;
                m_pq <= map_pq;
            end else begin
                m_v <= 1'b0;
            end
        end else if (in_fire) begin
            s_v  <= 1'b1;
            s_pq <= map_pq;
        end
    end

    // Completed output handshakes; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (out_fire) begin
            out_count <= out_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_gf256_to_gf16_stream.sv
// Directed bench for gf256_to_gf16_stream.
module tb_gf256_to_gf16_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_p;
    logic [3:0]  out_q;
    logic [15:0] out_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    gf256_to_gf16_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_q     (out_q),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fmap(input logic [7:0] g);
        logic [3:0] p;
        logic [3:0] q;
        q[0] = g[4] ^ g[5] ^ g[6];
        q[1] = g[1] ^ g[4] ^ g[6] ^ g[7];
        q[2] = g[2] ^ g[3] ^ g[5] ^ g[7];
        q[3] = g[5] ^ g[7];
        p[0] = g[0] ^ g[4] ^ g[5] ^ g[6];
        p[1] = g[1] ^ g[2];
        p[2] = g[1] ^ g[7];
        p[3] = g[2] ^ g[4];
        return {p, q};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    logic [7:0] held;
    int unsigned fires;
    int unsigned guard;

    initial begin
        // Reset values
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_count",     {16'd0, out_count}, 32'd0);
        chk("rst_pq",        {24'd0, out_p, out_q}, 32'h00);
        do_reset();

        // Single bytes, hand-computed results
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h00; step(); in_valid = 1'b0;
        chk("single_00", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, 8'h00});
        step();
        chk("single_00_gone", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1; in_data = 8'h01; step(); in_valid = 1'b0;
        chk("single_01", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, 8'h10});
        step();
        in_valid = 1'b1; in_data = 8'h02; step(); in_valid = 1'b0;
        chk("single_02", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, 8'h62});
        step();
        in_valid = 1'b1; in_data = 8'h80; step(); in_valid = 1'b0;
        chk("single_80", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, 8'h4E});
        step();
        in_valid = 1'b1; in_data = 8'hFF; step(); in_valid = 1'b0;
        chk("single_FF", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, 8'h01});
        step();
        chk("single_count", {16'd0, out_count}, 32'd5);

        // Exhaustive back-to-back sweep
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            chk("sweep", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, fmap(8'(i))});
            chk("sweep_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("sweep_drained", {31'd0, out_valid}, 32'd0);
        chk("sweep_count", {16'd0, out_count}, 32'h100);

        // Backpressure: stall two cycles after the first output
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h10;
        step();
        chk("bp_out10", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, fmap(8'h10)});
        out_ready = 1'b0; in_data = 8'h11;
        step();
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_hold1", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, fmap(8'h10)});
        in_data = 8'h12;
        step();
        chk("bp_in_ready_low2", {31'd0, in_ready}, 32'd0);
        chk("bp_hold2", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, fmap(8'h10)});
        out_ready = 1'b1;
        step();
        chk("bp_out11", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, fmap(8'h11)});
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_out12", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, fmap(8'h12)});
        in_data = 8'h13;
        step();
        chk("bp_out13", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, fmap(8'h13)});
        in_valid = 1'b0;
        step();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        chk("bp_count", {16'd0, out_count}, 32'd4);

        // Flush with M and S both full
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h20;
        step();
        in_data = 8'h21;
        step();
        chk("fl_full", {30'd0, out_valid, in_ready}, 32'b10);
        flush = 1'b1; in_data = 8'h22;
        #1;
        chk("fl_in_ready_during", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_after", {30'd0, out_valid, in_ready}, 32'b01);
        chk("fl_count", {16'd0, out_count}, 32'd0);
        out_ready = 1'b1;
        step();
        step();
        chk("fl_no_22", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream with S full
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h2F;
        step();
        in_data = 8'h30;
        step();
        out_ready = 1'b0; in_data = 8'h31;
        step();
        chk("ar_s_full", {31'd0, in_ready}, 32'd0);
        chk("ar_count_pre", {16'd0, out_count}, 32'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_pq", {24'd0, out_p, out_q}, 32'h00);
        chk("ar_count", {16'd0, out_count}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        step();
        chk("ar_no_stale", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1; in_data = 8'h40;
        step();
        in_valid = 1'b0;
        chk("ar_new", {23'd0, out_valid, out_p, out_q}, {23'd0, 1'b1, fmap(8'h40)});
        step();
        chk("ar_new_only", {31'd0, out_valid}, 32'd0);
        chk("ar_new_count", {16'd0, out_count}, 32'd1);

        // Counter wrap: 65537 handshakes from reset
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; held = 8'h00;
        fires = 0; guard = 0;
        while (fires < 65537 && guard < 70000) begin
            in_data = held;
            held    = held + 8'd1;
            @(negedge clk);
            if (out_valid) fires++;
            if (fires == 65537) in_valid = 1'b0;
            guard++;
        end
        chk("wrap_fires_reached", fires, 32'd65537);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("wrap_count", {16'd0, out_count}, 32'd1);
        chk("wrap_drained", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
